fan_pwm_drive: RTL

//   Downstream of the duty-selection stage. Converts the 0..100 duty command into a glitch-free

---
 rtl/fan_pkg.sv | 5 +
 rtl/pwm_period_cnt.sv | 19 +
 rtl/fan_pwm_drive.sv | 114 +++++++++++
 3 files changed

// File: rtl/fan_pkg.sv
// Shared constants and FSM encoding for the fan PWM drive.
package fan_pkg;
  localparam int DUTY_MAX = 100;
  typedef enum logic [1:0] {IDLE = 2'd0, KICK = 2'd1, RUN = 2'd2} fan_state_e;
endpackage

// File: rtl/pwm_period_cnt.sv
// Free-running PWM period counter; period_end marks the last cycle of each period.
module pwm_period_cnt #(
  parameter  int PERIOD_CNT = 2000,
  localparam int CW         = $clog2(PERIOD_CNT)
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  output logic [CW-1:0] cnt,
  output logic [CW-1:0] cnt_next,
  output logic          period_end
);
  assign period_end = (cnt == CW'(PERIOD_CNT - 1));
  assign cnt_next   = period_end ? '0 : cnt + CW'(1);

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) cnt <= '0;
    else            cnt <= cnt_next;
  end
endmodule

// File: rtl/fan_pwm_drive.sv
// Fan PWM driver: kick-start from standstill, slew-limited duty ramp, glitch-free
// output where the threshold only changes at period boundaries.
module fan_pwm_drive
  import fan_pkg::*;
#(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int PWM_FREQ     = 25_000,
  parameter int RAMP_PERIODS = 50,
  parameter int KICK_PERIODS = 250
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [6:0] duty_data,
  output logic       pwm_out,
  output logic       fan_en,
  output logic [6:0] cur_duty,
  output logic       period_end,
  output logic       ramp_busy
);
  localparam int PERIOD_CNT = CLK_FREQ / PWM_FREQ;
  localparam int STEP       = PERIOD_CNT / DUTY_MAX;
  localparam int CW         = $clog2(PERIOD_CNT);
  localparam int TW         = $clog2(PERIOD_CNT + 1);
  localparam int RW         = $clog2(RAMP_PERIODS + 1);
  localparam int KW         = $clog2(KICK_PERIODS + 1);

  fan_state_e    state, state_n;
  logic [6:0]    tgt, tgt_n, duty_n;
  logic [RW-1:0] ramp_cnt, ramp_n;
  logic [KW-1:0] kick_cnt, kick_n;
  logic [TW-1:0] thresh, thresh_n, thresh_nx;
  logic [CW-1:0] cnt, cnt_next;
  logic          pwm_n;

  pwm_period_cnt #(.PERIOD_CNT(PERIOD_CNT)) u_cnt (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .cnt       (cnt),
    .cnt_next  (cnt_next),
    .period_end(period_end)
  );

  assign tgt_n     = (duty_data > 7'(DUTY_MAX)) ? 7'(DUTY_MAX) : duty_data;
  assign fan_en    = (state != IDLE);
  assign ramp_busy = (state == RUN) && (cur_duty != tgt);

  always_comb begin
    state_n = state;
    duty_n  = cur_duty;
    ramp_n  = ramp_cnt;
    kick_n  = kick_cnt;
    if (period_end) begin
      case (state)
        IDLE: if (tgt != '0) begin
          state_n = KICK;
          kick_n  = '0;
        end
        KICK: begin
          kick_n = kick_cnt + KW'(1);
          if (tgt == '0) state_n = IDLE;
          else if (kick_cnt == KW'(KICK_PERIODS - 1)) begin
            state_n = RUN;
            duty_n  = tgt;
            ramp_n  = '0;
          end
        end
        RUN: begin
          if (cur_duty == '0 && tgt == '0) begin
            state_n = IDLE;
            ramp_n  = '0;
          end else if (cur_duty == tgt) ramp_n = '0;
          else if (ramp_cnt == RW'(RAMP_PERIODS - 1)) begin
            ramp_n = '0;
            duty_n = (cur_duty < tgt) ? cur_duty + 7'd1 : cur_duty - 7'd1;
          end else ramp_n = ramp_cnt + RW'(1);
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Threshold for the coming period follows the post-decision state.
  always_comb begin
    thresh_n = '0;
    case (state_n)
      RUN:     thresh_n = TW'(duty_n) * TW'(STEP);
      KICK:    thresh_n = TW'(PERIOD_CNT);
      default: thresh_n = '0;
    endcase
  end

  assign thresh_nx = period_end ? thresh_n : thresh;
  assign pwm_n     = (TW'(cnt_next) < thresh_nx);

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state    <= IDLE;
      tgt      <= '0;
      cur_duty <= '0;
      ramp_cnt <= '0;
      kick_cnt <= '0;
      thresh   <= '0;
      pwm_out  <= 1'b0;
    end else begin
      state    <= state_n;
      tgt      <= tgt_n;
      cur_duty <= duty_n;
      ramp_cnt <= ramp_n;
      kick_cnt <= kick_n;
      thresh   <= thresh_nx;
      pwm_out  <= pwm_n;
    end
  end
endmodule
